// File: rtl/arb_defs.sv
// Shared definitions for the LemonPC memory arbiter: FSM encoding, owner IDs
// and the byte-mask constants that mirror the mem_mask_* defines.
package arb_defs;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } arb_state_e;

    localparam logic ARB_IFU = 1'b0;
    localparam logic ARB_LSU = 1'b1;

    localparam logic [7:0] MEM_MASK_NONE  = 8'h00;
    localparam logic [7:0] MEM_MASK_BYTE  = 8'h01;
    localparam logic [7:0] MEM_MASK_HALF  = 8'h03;
    localparam logic [7:0] MEM_MASK_WORD  = 8'h0F;
    localparam logic [7:0] MEM_MASK_DWORD = 8'hFF;

endpackage

// File: rtl/rr_pick2.sv
// Two-way round-robin picker: a lone requester wins; under contention the
// requester that did not win last time is chosen. Output is one-hot (or zero).
module rr_pick2
    import arb_defs::*;
(
    input  logic [1:0] req_valid_i,
    input  logic       last_grant_i,
    output logic [1:0] grant_o
);

    always_comb begin
        grant_o          = 2'b00;
        grant_o[ARB_IFU] = req_valid_i[ARB_IFU] &&
                           (!req_valid_i[ARB_LSU] || (last_grant_i == ARB_LSU));
        grant_o[ARB_LSU] = req_valid_i[ARB_LSU] &&
                           (!req_valid_i[ARB_IFU] || (last_grant_i == ARB_IFU));
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one downstream memory port between IFU and LSU, one transaction at a
// time, with round-robin arbitration and registered FSM outputs.
module mem_arbiter
    import arb_defs::*;
#(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                if_req_valid,
    output logic                if_req_ready,
    input  logic [ADDR_W-1:0]   if_req_addr,
    output logic                if_resp_valid,
    input  logic                if_resp_ready,
    output logic [DATA_W-1:0]   if_resp_rdata,
    input  logic                ls_req_valid,
    output logic                ls_req_ready,
    input  logic [ADDR_W-1:0]   ls_req_addr,
    input  logic                ls_req_wen,
    input  logic [DATA_W-1:0]   ls_req_wdata,
    input  logic [DATA_W/8-1:0] ls_req_wmask,
    output logic                ls_resp_valid,
    input  logic                ls_resp_ready,
    output logic [DATA_W-1:0]   ls_resp_rdata,
    output logic                mem_valid,
    input  logic                mem_ready,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic                mem_wen,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_wmask,
    input  logic                mem_rvalid,
    input  logic [DATA_W-1:0]   mem_rdata,
    output logic                busy
);

    localparam int MASK_W = DATA_W / 8;

    arb_state_e          state_q;
    logic                last_grant_q;
    logic                owner_q;
    logic [ADDR_W-1:0]   addr_q;
    logic                wen_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [MASK_W-1:0]   wmask_q;
    logic [DATA_W-1:0]   rdata_q;
    logic                mem_valid_q;
    logic                if_resp_valid_q;
    logic                ls_resp_valid_q;
    logic                busy_q;

    logic [1:0]          grant;
    logic                resp_ready;

    rr_pick2 u_pick (
        .req_valid_i  ({ls_req_valid, if_req_valid}),
        .last_grant_i (last_grant_q),
        .grant_o      (grant)
    );

    // Readiness is gated by rst so nothing is accepted while reset is applied.
    assign if_req_ready = (state_q == ST_IDLE) && grant[ARB_IFU] && !rst;
    assign ls_req_ready = (state_q == ST_IDLE) && grant[ARB_LSU] && !rst;
    assign resp_ready   = (owner_q == ARB_IFU) ? if_resp_ready : ls_resp_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= ST_IDLE;
            last_grant_q    <= ARB_LSU;
            owner_q         <= ARB_IFU;
            addr_q          <= '0;
            wen_q           <= 1'b0;
            wdata_q         <= '0;
            wmask_q         <= '0;
            rdata_q         <= '0;
            mem_valid_q     <= 1'b0;
            if_resp_valid_q <= 1'b0;
            ls_resp_valid_q <= 1'b0;
            busy_q          <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (if_req_valid && if_req_ready) begin
                        owner_q      <= ARB_IFU;
                        last_grant_q <= ARB_IFU;
                        addr_q       <= if_req_addr;
                        wen_q        <= 1'b0;
                        wdata_q      <= '0;
                        wmask_q      <= '0;
                        state_q      <= ST_ISSUE;
                        mem_valid_q  <= 1'b1;
                        busy_q       <= 1'b1;
                    end else if (ls_req_valid && ls_req_ready) begin
                        owner_q      <= ARB_LSU;
                        last_grant_q <= ARB_LSU;
                        addr_q       <= ls_req_addr;
                        wen_q        <= ls_req_wen;
                        wdata_q      <= ls_req_wdata;
                        wmask_q      <= ls_req_wmask;
                        state_q      <= ST_ISSUE;
                        mem_valid_q  <= 1'b1;
                        busy_q       <= 1'b1;
                    end
                end
                ST_ISSUE: begin
                    // A response in the accepting cycle itself is not legal and is dropped.
                    if (mem_ready) begin
                        state_q     <= ST_WAIT;
                        mem_valid_q <= 1'b0;
                    end
                end
                ST_WAIT: begin
                    if (mem_rvalid) begin
                        rdata_q         <= mem_rdata;
                        state_q         <= ST_RESP;
                        if_resp_valid_q <= (owner_q == ARB_IFU);
                        ls_resp_valid_q <= (owner_q == ARB_LSU);
                    end
                end
                ST_RESP: begin
                    if (resp_ready) begin
                        state_q         <= ST_IDLE;
                        if_resp_valid_q <= 1'b0;
                        ls_resp_valid_q <= 1'b0;
                        busy_q          <= 1'b0;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign mem_valid     = mem_valid_q;
    assign mem_addr      = addr_q;
    assign mem_wen       = wen_q;
    assign mem_wdata     = wdata_q;
    assign mem_wmask     = wmask_q;
    assign if_resp_valid = if_resp_valid_q;
    assign ls_resp_valid = ls_resp_valid_q;
    assign if_resp_rdata = rdata_q;
    assign ls_resp_rdata = rdata_q;
    assign busy          = busy_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: inputs change on the falling edge, outputs
// are checked 1 time unit later, one immediate assertion per comparison.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req_valid, if_req_ready;
    logic [63:0] if_req_addr;
    logic        if_resp_valid, if_resp_ready;
    logic [63:0] if_resp_rdata;
    logic        ls_req_valid, ls_req_ready;
    logic [63:0] ls_req_addr;
    logic        ls_req_wen;
    logic [63:0] ls_req_wdata;
    logic [7:0]  ls_req_wmask;
    logic        ls_resp_valid, ls_resp_ready;
    logic [63:0] ls_resp_rdata;
    logic        mem_valid, mem_ready;
    logic [63:0] mem_addr;
    logic        mem_wen;
    logic [63:0] mem_wdata;
    logic [7:0]  mem_wmask;
    logic        mem_rvalid;
    logic [63:0] mem_rdata;
    logic        busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_arbiter #(.ADDR_W(64), .DATA_W(64)) dut (
        .clk           (clk),
        .rst           (rst),
        .if_req_valid  (if_req_valid),
        .if_req_ready  (if_req_ready),
        .if_req_addr   (if_req_addr),
        .if_resp_valid (if_resp_valid),
        .if_resp_ready (if_resp_ready),
        .if_resp_rdata (if_resp_rdata),
        .ls_req_valid  (ls_req_valid),
        .ls_req_ready  (ls_req_ready),
        .ls_req_addr   (ls_req_addr),
        .ls_req_wen    (ls_req_wen),
        .ls_req_wdata  (ls_req_wdata),
        .ls_req_wmask  (ls_req_wmask),
        .ls_resp_valid (ls_resp_valid),
        .ls_resp_ready (ls_resp_ready),
        .ls_resp_rdata (ls_resp_rdata),
        .mem_valid     (mem_valid),
        .mem_ready     (mem_ready),
        .mem_addr      (mem_addr),
        .mem_wen       (mem_wen),
        .mem_wdata     (mem_wdata),
        .mem_wmask     (mem_wmask),
        .mem_rvalid    (mem_rvalid),
        .mem_rdata     (mem_rdata),
        .busy          (busy)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic nx();
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1;
        if_req_valid = 0; if_req_addr = 0; if_resp_ready = 0;
        ls_req_valid = 0; ls_req_addr = 0; ls_req_wen = 0;
        ls_req_wdata = 0; ls_req_wmask = 0; ls_resp_ready = 0;
        mem_ready = 0; mem_rvalid = 0; mem_rdata = 0;

        // Reset state
        nx(); nx(); #1;
        chk("rst_mem_valid", {63'd0, mem_valid}, 64'd0);
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_if_resp_valid", {63'd0, if_resp_valid}, 64'd0);
        chk("rst_ls_resp_valid", {63'd0, ls_resp_valid}, 64'd0);
        chk("rst_mem_addr", mem_addr, 64'd0);
        chk("rst_if_rdata", if_resp_rdata, 64'd0);

        // IFU-only read, zero stall
        nx(); rst = 0;
        if_req_valid = 1; if_req_addr = 64'h8000_0000; if_resp_ready = 1; mem_ready = 1;
        #1;
        chk("t1_if_ready", {63'd0, if_req_ready}, 64'd1);
        chk("t1_ls_ready", {63'd0, ls_req_ready}, 64'd0);
        nx(); if_req_valid = 0; #1;
        chk("t1_mem_valid", {63'd0, mem_valid}, 64'd1);
        chk("t1_mem_addr", mem_addr, 64'h8000_0000);
        chk("t1_mem_wen", {63'd0, mem_wen}, 64'd0);
        chk("t1_mem_wmask", {56'd0, mem_wmask}, 64'd0);
        chk("t1_busy", {63'd0, busy}, 64'd1);
        chk("t1_ls_resp_t1", {63'd0, ls_resp_valid}, 64'd0);
        nx(); mem_rvalid = 1; mem_rdata = 64'h0010_0073; #1;
        chk("t1_mem_valid_wait", {63'd0, mem_valid}, 64'd0);
        chk("t1_if_resp_early", {63'd0, if_resp_valid}, 64'd0);
        nx(); mem_rvalid = 0; #1;
        chk("t1_if_resp_valid", {63'd0, if_resp_valid}, 64'd1);
        chk("t1_if_rdata", if_resp_rdata, 64'h0010_0073);
        chk("t1_ls_resp_t3", {63'd0, ls_resp_valid}, 64'd0);
        nx(); #1;
        chk("t1_idle_busy", {63'd0, busy}, 64'd0);
        chk("t1_idle_if_resp", {63'd0, if_resp_valid}, 64'd0);

        // LSU write
        ls_req_valid = 1; ls_req_addr = 64'h8000_1008; ls_req_wen = 1;
        ls_req_wdata = 64'hDEAD_BEEF; ls_req_wmask = 8'h0F; ls_resp_ready = 1;
        #1;
        chk("t2_ls_ready", {63'd0, ls_req_ready}, 64'd1);
        nx(); ls_req_valid = 0; ls_req_wen = 0; ls_req_wdata = 0; ls_req_wmask = 0; #1;
        chk("t2_mem_valid", {63'd0, mem_valid}, 64'd1);
        chk("t2_mem_wen", {63'd0, mem_wen}, 64'd1);
        chk("t2_mem_wmask", {56'd0, mem_wmask}, 64'h0F);
        chk("t2_mem_addr", mem_addr, 64'h8000_1008);
        chk("t2_mem_wdata", mem_wdata, 64'hDEAD_BEEF);
        nx(); mem_rvalid = 1; mem_rdata = 64'h1234; #1;
        chk("t2_ls_resp_early", {63'd0, ls_resp_valid}, 64'd0);
        nx(); mem_rvalid = 0; #1;
        chk("t2_ls_resp_valid", {63'd0, ls_resp_valid}, 64'd1);
        chk("t2_if_resp_valid", {63'd0, if_resp_valid}, 64'd0);
        nx(); #1;
        chk("t2_idle_busy", {63'd0, busy}, 64'd0);

        // Simultaneous requests from reset: IFU, LSU, IFU, LSU
        rst = 1;
        nx(); rst = 0;
        if_req_valid = 1; if_req_addr = 64'h1000;
        ls_req_valid = 1; ls_req_addr = 64'h2000; ls_req_wen = 0;
        if_resp_ready = 1; ls_resp_ready = 1; mem_ready = 1;
        for (int i = 0; i < 4; i++) begin
            logic exp_lsu;
            exp_lsu = (i % 2) == 1;
            #1;
            chk($sformatf("t3_if_ready_%0d", i), {63'd0, if_req_ready}, {63'd0, !exp_lsu});
            chk($sformatf("t3_ls_ready_%0d", i), {63'd0, ls_req_ready}, {63'd0, exp_lsu});
            nx(); #1;
            chk($sformatf("t3_mem_addr_%0d", i), mem_addr, exp_lsu ? 64'h2000 : 64'h1000);
            chk($sformatf("t3_ready_issue_%0d", i), {62'd0, if_req_ready, ls_req_ready}, 64'd0);
            nx(); mem_rvalid = 1; mem_rdata = 64'hA0 + 64'(i); #1;
            nx(); mem_rvalid = 0; #1;
            chk($sformatf("t3_if_resp_%0d", i), {63'd0, if_resp_valid}, {63'd0, !exp_lsu});
            chk($sformatf("t3_ls_resp_%0d", i), {63'd0, ls_resp_valid}, {63'd0, exp_lsu});
            chk($sformatf("t3_rdata_%0d", i), exp_lsu ? ls_resp_rdata : if_resp_rdata, 64'hA0 + 64'(i));
            nx();
            if (i == 3) begin
                if_req_valid = 0;
                ls_req_valid = 0;
            end
        end

        // Backpressure: mem_ready low 5 cycles, then ls_resp_ready low 3 cycles
        ls_req_valid = 1; ls_req_addr = 64'h3000; ls_req_wen = 0;
        mem_ready = 0; ls_resp_ready = 0;
        #1;
        chk("t4_ls_ready", {63'd0, ls_req_ready}, 64'd1);
        nx(); ls_req_valid = 0; if_req_valid = 1;
        for (int s = 0; s < 5; s++) begin
            if (s > 0) nx();
            mem_rvalid = (s == 1);
            mem_rdata  = 64'hBAD;
            #1;
            chk($sformatf("t4_stall_valid_%0d", s), {63'd0, mem_valid}, 64'd1);
            chk($sformatf("t4_stall_addr_%0d", s), mem_addr, 64'h3000);
            chk($sformatf("t4_stall_ready_%0d", s), {62'd0, if_req_ready, ls_req_ready}, 64'd0);
        end
        nx(); mem_ready = 1; mem_rvalid = 0; #1;
        chk("t4_issue_release", {63'd0, mem_valid}, 64'd1);
        nx(); mem_ready = 0; mem_rvalid = 1; mem_rdata = 64'hCAFE_F00D; #1;
        nx(); mem_rvalid = 0;
        for (int r = 0; r < 3; r++) begin
            if (r > 0) nx();
            #1;
            chk($sformatf("t4_resp_valid_%0d", r), {63'd0, ls_resp_valid}, 64'd1);
            chk($sformatf("t4_resp_rdata_%0d", r), ls_resp_rdata, 64'hCAFE_F00D);
            chk($sformatf("t4_resp_ready_%0d", r), {62'd0, if_req_ready, ls_req_ready}, 64'd0);
            chk($sformatf("t4_if_resp_%0d", r), {63'd0, if_resp_valid}, 64'd0);
        end
        nx(); ls_resp_ready = 1; if_req_valid = 0; #1;
        chk("t4_resp_last", {63'd0, ls_resp_valid}, 64'd1);
        nx(); #1;
        chk("t4_idle_busy", {63'd0, busy}, 64'd0);
        chk("t4_idle_ls_resp", {63'd0, ls_resp_valid}, 64'd0);

        // Reset in WAIT, then a late mem_rvalid
        if_req_valid = 1; if_req_addr = 64'h4000; mem_ready = 1; if_resp_ready = 1;
        #1;
        chk("t5_if_ready", {63'd0, if_req_ready}, 64'd1);
        nx(); if_req_valid = 0; #1;
        chk("t5_mem_valid", {63'd0, mem_valid}, 64'd1);
        nx(); rst = 1; #1;
        chk("t5_wait_busy", {63'd0, busy}, 64'd1);
        nx(); rst = 0; mem_rvalid = 1; mem_rdata = 64'h55; #1;
        chk("t5_rst_busy", {63'd0, busy}, 64'd0);
        chk("t5_rst_mem_valid", {63'd0, mem_valid}, 64'd0);
        chk("t5_rst_if_resp", {63'd0, if_resp_valid}, 64'd0);
        chk("t5_rst_mem_addr", mem_addr, 64'd0);
        nx(); mem_rvalid = 0; #1;
        chk("t5_late_busy", {63'd0, busy}, 64'd0);
        chk("t5_late_if_resp", {63'd0, if_resp_valid}, 64'd0);
        chk("t5_late_ls_resp", {63'd0, ls_resp_valid}, 64'd0);

        // Stray mem_rvalid in IDLE
        nx(); mem_rvalid = 1; mem_rdata = 64'h77; #1;
        chk("t6_busy_during", {63'd0, busy}, 64'd0);
        nx(); mem_rvalid = 0; #1;
        chk("t6_busy", {63'd0, busy}, 64'd0);
        chk("t6_mem_valid", {63'd0, mem_valid}, 64'd0);
        chk("t6_if_resp", {63'd0, if_resp_valid}, 64'd0);
        chk("t6_ls_resp", {63'd0, ls_resp_valid}, 64'd0);
        chk("t6_rdata", if_resp_rdata, 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
